hamming_dec_arbiter: RTL and testbench

- Shares one Hamming(12,8) single-error-correcting decode datapath among NREQ requesters.
- Arbitrates round-robin and accepts at most one codeword per cycle.
- Decodes through a two-stage pipeline and returns one response stream tagged with the requester index.
- Sits between the per-channel receive buffers and the consumers of 8-bit corrected data, and keeps saturating error statistics.

---
 rtl/hamming_pkg.sv | 31 +++
 rtl/hamming_dec_arbiter_if.sv | 32 +++
 rtl/hamming_dec_arbiter_core.sv | 39 +++
 rtl/hamming_dec_arbiter.sv | 131 +++++++++++++
 tb/tb_hamming_dec_arbiter.sv | 290 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/hamming_pkg.sv
// Shared definitions for the Hamming(12,8) decode arbiter.
// Codeword bit cw[i-1] holds Hamming position i (1..12). Parity bits sit
// at positions 1, 2, 4 and 8. Data bits d[0..7] sit at 3, 5, 6, 7, 9, 10, 11, 12.
package hamming_pkg;

    localparam int CW_W   = 12;
    localparam int DATA_W = 8;
    localparam int SYN_W  = 4;

    // Syndrome bit k covers every position whose index has bit k set.
    // Bit p-1 of each mask stands for position p.
    localparam logic [SYN_W-1:0][CW_W-1:0] SYN_MASK = {
        12'hF80,   // s[3]: positions 8..12
        12'h878,   // s[2]: positions 4..7, 12
        12'h666,   // s[1]: positions 2, 3, 6, 7, 10, 11
        12'h555    // s[0]: odd positions
    };

    // Hamming position (1-based) that carries data bit d[k].
    localparam logic [DATA_W-1:0][3:0] DATA_POS = {
        4'd12, 4'd11, 4'd10, 4'd9, 4'd7, 4'd6, 4'd5, 4'd3
    };

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic              corr;
        logic              uncorr;
        logic [SYN_W-1:0]  syn;
    } hamming_rsp_t;

endpackage

// File: rtl/hamming_dec_arbiter_if.sv
// Request/response bus of the shared Hamming decoder.
//   req_valid / req_cw / req_ready : NREQ requester lanes, 12-bit codeword each
//   rsp_*                          : single tagged response stream
// slave  : decoder side
// master : requester/consumer side
interface hamming_dec_arbiter_if
    import hamming_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int IDW  = 2
);
    logic [NREQ-1:0]      req_valid;
    logic [CW_W*NREQ-1:0] req_cw;
    logic [NREQ-1:0]      req_ready;
    logic                 rsp_valid;
    logic                 rsp_ready;
    logic [IDW-1:0]       rsp_id;
    logic [DATA_W-1:0]    rsp_data;
    logic                 rsp_corr;
    logic                 rsp_uncorr;
    logic [SYN_W-1:0]     rsp_syn;

    modport slave (
        input  req_valid, req_cw, rsp_ready,
        output req_ready, rsp_valid, rsp_id, rsp_data, rsp_corr, rsp_uncorr, rsp_syn
    );

    modport master (
        output req_valid, req_cw, rsp_ready,
        input  req_ready, rsp_valid, rsp_id, rsp_data, rsp_corr, rsp_uncorr, rsp_syn
    );
endinterface

// File: rtl/hamming_dec_arbiter_core.sv
// Combinational Hamming(12,8) SEC decode: syndrome, single-bit correction
// and data extraction.
//   i_cw  : 12-bit codeword
//   o_rsp : data, corr/uncorr flags and raw syndrome
module hamming12_core
    import hamming_pkg::*;
(
    input  logic [CW_W-1:0] i_cw,
    output hamming_rsp_t    o_rsp
);

    logic [SYN_W-1:0] w_syn;
    logic             w_in_range;
    logic [CW_W-1:0]  w_flip;
    logic [CW_W-1:0]  w_fixed;

    always_comb begin
        w_syn = '0;
        for (int k = 0; k < SYN_W; k++) begin
            w_syn[k] = ^(i_cw & SYN_MASK[k]);
        end
    end

    // Syndromes 13..15 point outside the codeword: flagged, never corrected.
    assign w_in_range = (w_syn != '0) && (w_syn <= 4'd12);
    assign w_flip     = w_in_range ? (CW_W'(1) << (w_syn - 4'd1)) : '0;
    assign w_fixed    = i_cw ^ w_flip;

    always_comb begin
        o_rsp = '0;
        for (int k = 0; k < DATA_W; k++) begin
            o_rsp.data[k] = w_fixed[DATA_POS[k] - 4'd1];
        end
        o_rsp.corr   = w_in_range;
        o_rsp.uncorr = (w_syn >= 4'd13);
        o_rsp.syn    = w_syn;
    end

endmodule

// File: rtl/hamming_dec_arbiter.sv
// Round-robin arbiter in front of one shared two-stage Hamming(12,8) decoder.
//   clk, rst_n  : clock, async active-low reset
//   clr_cnt     : synchronous clear of both statistics counters
//   cnt_corr    : saturating count of delivered corrected responses
//   cnt_uncorr  : saturating count of delivered uncorrectable responses
//   bus         : request lanes in, tagged response stream out
module hamming_dec_arbiter
    import hamming_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int IDW  = 2,
    parameter int CNTW = 16
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            clr_cnt,
    output logic [CNTW-1:0] cnt_corr,
    output logic [CNTW-1:0] cnt_uncorr,
    hamming_dec_arbiter_if.slave bus
);

    logic [IDW-1:0]    r_ptr;
    logic              r_s1_valid;
    logic [CW_W-1:0]   r_s1_cw;
    logic [IDW-1:0]    r_s1_id;
    logic              r_s2_valid;
    logic [IDW-1:0]    r_s2_id;
    hamming_rsp_t      r_s2_rsp;
    logic [CNTW-1:0]   r_cnt_corr;
    logic [CNTW-1:0]   r_cnt_uncorr;

    logic              w_adv2;
    logic              w_adv1;
    logic              w_gnt_found;
    logic [IDW-1:0]    w_gnt_idx;
    logic [IDW-1:0]    w_cand;
    logic              w_accept;
    logic              w_deliver;
    logic [NREQ-1:0]   w_req_ready;
    hamming_rsp_t      w_core_rsp;

    assign w_adv2    = !r_s2_valid || bus.rsp_ready;
    assign w_adv1    = !r_s1_valid || w_adv2;
    assign w_accept  = w_gnt_found && w_adv1;
    assign w_deliver = r_s2_valid && bus.rsp_ready;

    // First valid requester scanning ptr, ptr+1, ... modulo NREQ.
    always_comb begin
        w_gnt_found = 1'b0;
        w_gnt_idx   = '0;
        w_cand      = '0;
        for (int k = 0; k < NREQ; k++) begin
            w_cand = IDW'((int'(r_ptr) + k) % NREQ);
            if (!w_gnt_found && bus.req_valid[w_cand]) begin
                w_gnt_found = 1'b1;
                w_gnt_idx   = w_cand;
            end
        end
    end

    always_comb begin
        w_req_ready = '0;
        if (w_accept) begin
            w_req_ready[w_gnt_idx] = 1'b1;
        end
    end

    assign bus.req_ready = w_req_ready;

    hamming12_core u_core (
        .i_cw  (r_s1_cw),
        .o_rsp (w_core_rsp)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr      <= '0;
            r_s1_valid <= 1'b0;
            r_s1_cw    <= '0;
            r_s1_id    <= '0;
            r_s2_valid <= 1'b0;
            r_s2_id    <= '0;
            r_s2_rsp   <= '0;
        end else begin
            // Stage 2 before stage 1 in source order only for readability;
            // both sample the pre-edge state.
            if (w_adv2) begin
                r_s2_valid <= r_s1_valid;
                if (r_s1_valid) begin
                    r_s2_id  <= r_s1_id;
                    r_s2_rsp <= w_core_rsp;
                end
            end
            if (w_adv1) begin
                r_s1_valid <= w_accept;
                if (w_accept) begin
                    r_s1_cw <= bus.req_cw[int'(w_gnt_idx)*CW_W +: CW_W];
                    r_s1_id <= w_gnt_idx;
                    r_ptr   <= (int'(w_gnt_idx) == NREQ - 1) ? '0 : w_gnt_idx + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt_corr   <= '0;
            r_cnt_uncorr <= '0;
        end else if (clr_cnt) begin
            r_cnt_corr   <= '0;
            r_cnt_uncorr <= '0;
        end else if (w_deliver) begin
            if (r_s2_rsp.corr && (r_cnt_corr != '1)) begin
                r_cnt_corr <= r_cnt_corr + 1'b1;
            end
            if (r_s2_rsp.uncorr && (r_cnt_uncorr != '1)) begin
                r_cnt_uncorr <= r_cnt_uncorr + 1'b1;
            end
        end
    end

    assign cnt_corr       = r_cnt_corr;
    assign cnt_uncorr     = r_cnt_uncorr;
    assign bus.rsp_valid  = r_s2_valid;
    assign bus.rsp_id     = r_s2_id;
    assign bus.rsp_data   = r_s2_rsp.data;
    assign bus.rsp_corr   = r_s2_rsp.corr;
    assign bus.rsp_uncorr = r_s2_rsp.uncorr;
    assign bus.rsp_syn    = r_s2_rsp.syn;

endmodule

// File: tb/tb_hamming_dec_arbiter.sv
// Bench for hamming_dec_arbiter. The reference decodes by XOR-ing the
// indices of all set positions, and tracks the pipeline as two occupancy
// slots advanced by the handshake rules. Counters use a narrow CNTW so
// saturation is reached in a few dozen cycles.
module tb_hamming_dec_arbiter;
    import hamming_pkg::*;

    localparam int NREQ = 4;
    localparam int IDW  = 2;
    localparam int CNTW = 6;
    localparam int CMAX = (1 << CNTW) - 1;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            clr_cnt = 1'b0;
    logic [CNTW-1:0] cnt_corr;
    logic [CNTW-1:0] cnt_uncorr;

    hamming_dec_arbiter_if #(.NREQ(NREQ), .IDW(IDW)) bus ();

    hamming_dec_arbiter #(.NREQ(NREQ), .IDW(IDW), .CNTW(CNTW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .clr_cnt    (clr_cnt),
        .cnt_corr   (cnt_corr),
        .cnt_uncorr (cnt_uncorr),
        .bus        (bus.slave)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // reference model state
    int          m_ptr;
    bit          m_s1v, m_s2v;
    logic [11:0] m_s1_cw, m_s2_cw;
    int          m_s1_id, m_s2_id;
    int          m_cc, m_cu;

    int obs_acc[$];
    int obs_rsp[$];

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // returns {syn[3:0], corr, uncorr, data[7:0]}
    function automatic logic [13:0] ref_decode(input logic [11:0] cw);
        int dpos [8];
        int s;
        logic [11:0] fixed;
        logic [7:0]  d;
        dpos = '{3, 5, 6, 7, 9, 10, 11, 12};
        s = 0;
        for (int p = 1; p <= 12; p++) if (cw[p-1]) s = s ^ p;
        fixed = cw;
        if (s >= 1 && s <= 12) fixed[s-1] = ~fixed[s-1];
        for (int k = 0; k < 8; k++) d[k] = fixed[dpos[k]-1];
        return {4'(s), (s >= 1 && s <= 12), (s >= 13), d};
    endfunction

    function automatic logic [11:0] encode(input logic [7:0] d);
        int dpos [8];
        int s;
        logic [11:0] cw;
        dpos = '{3, 5, 6, 7, 9, 10, 11, 12};
        cw = '0;
        s = 0;
        for (int k = 0; k < 8; k++) cw[dpos[k]-1] = d[k];
        for (int p = 1; p <= 12; p++) if (cw[p-1]) s = s ^ p;
        cw[0] = s[0];
        cw[1] = s[1];
        cw[3] = s[2];
        cw[7] = s[3];
        return cw;
    endfunction

    function automatic logic [11:0] one_err_cw();
        logic [11:0] cw;
        cw = encode(8'($urandom));
        cw[$urandom_range(11, 0)] ^= 1'b1;
        return cw;
    endfunction

    task automatic model_reset();
        m_ptr = 0; m_s1v = 0; m_s2v = 0; m_cc = 0; m_cu = 0;
    endtask

    task automatic cycle(input logic [NREQ-1:0] v, input logic [12*NREQ-1:0] cw,
                         input logic rdy, input logic clr);
        bit adv1, adv2, hs;
        int g;
        logic [NREQ-1:0] exp_ready;
        logic [13:0] e;
        @(negedge clk);
        bus.req_valid = v;
        bus.req_cw    = cw;
        bus.rsp_ready = rdy;
        clr_cnt       = clr;
        #1;
        adv2 = !m_s2v || rdy;
        adv1 = !m_s1v || adv2;
        g = -1;
        for (int k = 0; k < NREQ; k++) begin
            int j;
            j = (m_ptr + k) % NREQ;
            if (g < 0 && v[j]) g = j;
        end
        exp_ready = '0;
        if (adv1 && g >= 0) exp_ready[g] = 1'b1;
        check_val("req_ready", 32'(bus.req_ready), 32'(exp_ready));
        check_val("rsp_valid", 32'(bus.rsp_valid), 32'(m_s2v));
        if (m_s2v) begin
            e = ref_decode(m_s2_cw);
            check_val("rsp_id", 32'(bus.rsp_id), 32'(m_s2_id));
            check_val("rsp_data", 32'(bus.rsp_data), 32'(e[7:0]));
            check_val("rsp_flags", {30'd0, bus.rsp_corr, bus.rsp_uncorr}, {30'd0, e[9], e[8]});
            check_val("rsp_syn", 32'(bus.rsp_syn), 32'(e[13:10]));
        end
        check_val("cnt_corr", 32'(cnt_corr), 32'(m_cc));
        check_val("cnt_uncorr", 32'(cnt_uncorr), 32'(m_cu));
        for (int b = 0; b < NREQ; b++) if (bus.req_ready[b]) obs_acc.push_back(b);
        if (bus.rsp_valid && rdy) obs_rsp.push_back(int'(bus.rsp_id));
        // model update for the coming edge
        hs = m_s2v && rdy;
        if (clr) begin
            m_cc = 0; m_cu = 0;
        end else if (hs) begin
            e = ref_decode(m_s2_cw);
            if (e[9] && m_cc < CMAX) m_cc++;
            if (e[8] && m_cu < CMAX) m_cu++;
        end
        if (adv2) begin
            m_s2v = m_s1v;
            if (m_s1v) begin m_s2_cw = m_s1_cw; m_s2_id = m_s1_id; end
        end
        if (adv1) begin
            m_s1v = (g >= 0);
            if (g >= 0) begin
                m_s1_cw = cw[12*g +: 12];
                m_s1_id = g;
                m_ptr   = (g + 1) % NREQ;
            end
        end
    endtask

    task automatic peek();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle('0, '0, 1'b1, 1'b0);
    endtask

    function automatic logic [12*NREQ-1:0] rand_lanes();
        logic [12*NREQ-1:0] r;
        for (int i = 0; i < NREQ; i++) r[12*i +: 12] = 12'($urandom);
        return r;
    endfunction

    initial begin
        int start;
        logic [12*NREQ-1:0] lanes;
        bus.req_valid = '0;
        bus.req_cw    = '0;
        bus.rsp_ready = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        #1;
        check_val("reset_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        check_val("reset_rsp_fields", {bus.rsp_id, bus.rsp_data, bus.rsp_corr, bus.rsp_uncorr, bus.rsp_syn}, 32'd0);
        check_val("reset_req_ready", 32'(bus.req_ready), 32'd0);
        rst_n = 1'b1;

        // clean decode
        lanes = '0; lanes[11:0] = 12'hF77;
        cycle(4'b0001, lanes, 1'b1, 1'b0);
        idle(1);
        peek();
        check_val("clean_valid", 32'(bus.rsp_valid), 32'd1);
        check_val("clean_id", 32'(bus.rsp_id), 32'd0);
        check_val("clean_data", 32'(bus.rsp_data), 32'hFF);
        check_val("clean_syn_flags", {bus.rsp_syn, bus.rsp_corr, bus.rsp_uncorr}, 32'd0);

        // single error at position 5
        lanes[11:0] = 12'hF67;
        cycle(4'b0001, lanes, 1'b1, 1'b0);
        idle(1);
        peek();
        check_val("sec_data", 32'(bus.rsp_data), 32'hFF);
        check_val("sec_syn", 32'(bus.rsp_syn), 32'd5);
        check_val("sec_corr", 32'(bus.rsp_corr), 32'd1);
        idle(1);
        peek();
        check_val("sec_cnt_corr", 32'(cnt_corr), 32'd1);

        // uncorrectable, syndrome 13
        lanes[11:0] = 12'h801;
        cycle(4'b0001, lanes, 1'b1, 1'b0);
        idle(1);
        peek();
        check_val("unc_syn", 32'(bus.rsp_syn), 32'd13);
        check_val("unc_flag", 32'(bus.rsp_uncorr), 32'd1);
        check_val("unc_data", 32'(bus.rsp_data), 32'h80);
        idle(1);
        peek();
        check_val("unc_cnt", 32'(cnt_uncorr), 32'd1);
        idle(2);

        // fairness: all valid, consumer always ready
        obs_acc.delete(); obs_rsp.delete();
        start = m_ptr;
        for (int i = 0; i < 12; i++) cycle('1, rand_lanes(), 1'b1, 1'b0);
        check_val("fair_acc_count", 32'(obs_acc.size()), 32'd12);
        check_val("fair_rsp_count", 32'(obs_rsp.size()), 32'd10);
        for (int i = 0; i < obs_acc.size(); i++)
            check_val("fair_acc_order", 32'(obs_acc[i]), 32'((start + i) % NREQ));
        for (int i = 0; i < obs_rsp.size(); i++)
            check_val("fair_rsp_order", 32'(obs_rsp[i]), 32'((start + i) % NREQ));
        idle(3);

        // back-pressure with requester 2 streaming
        obs_acc.delete(); obs_rsp.delete();
        for (int i = 0; i < 5; i++) cycle(4'b0100, rand_lanes(), 1'b0, 1'b0);
        check_val("bp_accepts", 32'(obs_acc.size()), 32'd2);
        check_val("bp_req_ready", 32'(bus.req_ready), 32'd0);
        for (int i = 0; i < 4; i++) cycle(4'b0100, rand_lanes(), 1'b1, 1'b0);
        idle(3);
        check_val("bp_total_acc", 32'(obs_acc.size()), 32'd6);
        check_val("bp_total_rsp", 32'(obs_rsp.size()), 32'd6);

        // randomized traffic
        for (int i = 0; i < 400; i++)
            cycle(NREQ'($urandom), rand_lanes(), ($urandom_range(3, 0) != 0),
                  ($urandom_range(49, 0) == 0));
        idle(3);

        // saturation of cnt_corr
        for (int i = 0; i < 3 * CMAX && m_cc < CMAX; i++) begin
            lanes = '0; lanes[11:0] = one_err_cw();
            cycle(4'b0001, lanes, 1'b1, 1'b0);
        end
        for (int i = 0; i < 3; i++) begin
            lanes = '0; lanes[11:0] = one_err_cw();
            cycle(4'b0001, lanes, 1'b1, 1'b0);
        end
        idle(3);
        peek();
        check_val("sat_cnt_corr", 32'(cnt_corr), CMAX);

        // clear coinciding with a corrected handshake
        for (int i = 0; i < 3; i++) begin
            lanes = '0; lanes[11:0] = one_err_cw();
            cycle(4'b0001, lanes, 1'b1, 1'b0);
        end
        lanes = '0; lanes[11:0] = one_err_cw();
        cycle(4'b0001, lanes, 1'b1, 1'b1);
        peek();
        check_val("clr_cnt_corr", 32'(cnt_corr), 32'd0);
        idle(3);

        // reset with a full pipeline
        for (int i = 0; i < 3; i++) cycle('1, rand_lanes(), 1'b0, 1'b0);
        @(negedge clk);
        bus.req_valid = '0;
        rst_n = 1'b0;
        #1;
        check_val("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        check_val("rst_rsp_fields", {bus.rsp_id, bus.rsp_data, bus.rsp_corr, bus.rsp_uncorr, bus.rsp_syn}, 32'd0);
        check_val("rst_counters", {cnt_corr, cnt_uncorr}, 32'd0);
        check_val("rst_req_ready", 32'(bus.req_ready), 32'd0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        idle(4);
        for (int i = 0; i < 20; i++) cycle(NREQ'($urandom), rand_lanes(), 1'b1, 1'b0);
        idle(3);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
